// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light controller's processor-side port logic:
// port addresses, lamp encodings and the green-light timer states.
package tl_pkg;

  localparam logic [7:0] PORT_CE     = 8'h01;
  localparam logic [7:0] PORT_GREEN  = 8'h02;
  localparam logic [7:0] PORT_LIGHTS = 8'h03;
  localparam logic [7:0] PORT_TIMER  = 8'h04;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic {IDLE, RUN} timer_state_t;

  // A lamp field must light exactly one lamp; anything else falls back to the safe value.
  function automatic logic [2:0] safe_light(input logic [2:0] field, input logic [2:0] safe);
    return ((field == RED) || (field == YEL) || (field == GRN)) ? field : safe;
  endfunction

endpackage

// File: rtl/gl_countdown.sv
// Seconds-based green-light countdown. Commands (stop over load) take priority
// over a tick; o_expire pulses combinationally on the edge where the count finishes.
module gl_countdown
  import tl_pkg::*;
#(
  parameter int TIME_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_stop,
  input  logic              i_tick,
  input  logic              i_en,
  input  logic [TIME_W-1:0] i_load_val,
  output logic [TIME_W-1:0] o_remaining,
  output logic              o_busy,
  output logic              o_expire
);

  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  timer_state_t      r_state;
  timer_state_t      w_next_state;
  logic [TIME_W-1:0] r_remaining;
  logic [TIME_W-1:0] w_next_remaining;
  logic              w_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
    end
  end

  // Loading a zero duration counts as an immediate expiry rather than an empty run.
  always_comb begin
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    w_expire         = 1'b0;
    if (i_stop) begin
      w_next_state     = IDLE;
      w_next_remaining = '0;
    end else if (i_load) begin
      if (i_load_val == '0) begin
        w_next_state     = IDLE;
        w_next_remaining = '0;
        w_expire         = 1'b1;
      end else begin
        w_next_state     = RUN;
        w_next_remaining = i_load_val;
      end
    end else if ((r_state == RUN) && i_tick && i_en) begin
      if (r_remaining <= ONE) begin
        w_next_state     = IDLE;
        w_next_remaining = '0;
        w_expire         = 1'b1;
      end else begin
        w_next_remaining = r_remaining - ONE;
      end
    end
  end

  assign o_remaining = r_remaining;
  assign o_busy      = (r_state == RUN);
  assign o_expire    = w_expire;

endmodule

// File: rtl/out_port_regs.sv
// Output-side port decoder of the soft processor: captures writes into the
// clock-enable, green-time, lamp and timer-command registers and latches the expiry interrupt.
module out_port_regs
  import tl_pkg::*;
#(
  parameter int         TIME_W     = 6,
  parameter logic [2:0] LIGHT_SAFE = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        port_id,
  input  logic [7:0]        out_port,
  input  logic              write_strobe,
  input  logic              sec_tick,
  input  logic              interrupt_ack,
  output logic              ce,
  output logic [TIME_W-1:0] green_time,
  output logic [2:0]        ns_light,
  output logic [2:0]        ew_light,
  output logic              ped_walk,
  output logic              timer_busy,
  output logic [TIME_W-1:0] remaining,
  output logic              interrupt
);

  logic              r_ce;
  logic [TIME_W-1:0] r_green_time;
  logic [2:0]        r_ns_light;
  logic [2:0]        r_ew_light;
  logic              r_ped_walk;
  logic              r_interrupt;

  logic [2:0] w_ns_chk;
  logic [2:0] w_ew_chk;
  logic       w_both_green;
  logic [2:0] w_ns_final;
  logic [2:0] w_ew_final;
  logic       w_ped_final;
  logic       w_wr_timer;
  logic       w_start;
  logic       w_stop;
  logic       w_expire;

  // Walk is refused whenever a field asks for green, even if the clash check then reds both.
  always_comb begin
    w_ns_chk     = safe_light(out_port[2:0], LIGHT_SAFE);
    w_ew_chk     = safe_light(out_port[5:3], LIGHT_SAFE);
    w_both_green = (w_ns_chk == GRN) && (w_ew_chk == GRN);
    w_ns_final   = w_both_green ? LIGHT_SAFE : w_ns_chk;
    w_ew_final   = w_both_green ? LIGHT_SAFE : w_ew_chk;
    w_ped_final  = out_port[6] && (w_ns_chk != GRN) && (w_ew_chk != GRN);
  end

  assign w_wr_timer = write_strobe && (port_id == PORT_TIMER);
  assign w_start    = w_wr_timer && out_port[0] && !out_port[1];
  assign w_stop     = w_wr_timer && out_port[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce         <= 1'b0;
      r_green_time <= '0;
      r_ns_light   <= RED;
      r_ew_light   <= RED;
      r_ped_walk   <= 1'b0;
    end else if (write_strobe) begin
      case (port_id)
        PORT_CE:     r_ce <= out_port[0];
        PORT_GREEN:  r_green_time <= out_port[TIME_W-1:0];
        PORT_LIGHTS: begin
          r_ns_light <= w_ns_final;
          r_ew_light <= w_ew_final;
          r_ped_walk <= w_ped_final;
        end
        default: ;
      endcase
    end
  end

  gl_countdown #(
    .TIME_W(TIME_W)
  ) u_countdown (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start),
    .i_stop     (w_stop),
    .i_tick     (sec_tick),
    .i_en       (r_ce),
    .i_load_val (r_green_time),
    .o_remaining(remaining),
    .o_busy     (timer_busy),
    .o_expire   (w_expire)
  );

  // A fresh expiry beats an acknowledge arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_interrupt <= 1'b0;
    end else if (w_expire) begin
      r_interrupt <= 1'b1;
    end else if (interrupt_ack) begin
      r_interrupt <= 1'b0;
    end
  end

  assign ce         = r_ce;
  assign green_time = r_green_time;
  assign ns_light   = r_ns_light;
  assign ew_light   = r_ew_light;
  assign ped_walk   = r_ped_walk;
  assign interrupt  = r_interrupt;

endmodule

// File: tb/tb_out_port_regs.sv
// Directed and randomized bench for out_port_regs, checked against a
// behavioural model of the port map, lamp safety rules and timer.
module tb_out_port_regs;

  localparam int TIME_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        port_id = 8'h00;
  logic [7:0]        out_port = 8'h00;
  logic              write_strobe = 1'b0;
  logic              sec_tick = 1'b0;
  logic              interrupt_ack = 1'b0;
  logic              ce;
  logic [TIME_W-1:0] green_time;
  logic [2:0]        ns_light;
  logic [2:0]        ew_light;
  logic              ped_walk;
  logic              timer_busy;
  logic [TIME_W-1:0] remaining;
  logic              interrupt;

  int testCount = 0;
  int failCount = 0;

  int mCe, mGreen, mRem, mBusy, mInt, mNs, mEw, mPed;

  out_port_regs #(
    .TIME_W    (TIME_W),
    .LIGHT_SAFE(3'b100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .sec_tick     (sec_tick),
    .interrupt_ack(interrupt_ack),
    .ce           (ce),
    .green_time   (green_time),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .ped_walk     (ped_walk),
    .timer_busy   (timer_busy),
    .remaining    (remaining),
    .interrupt    (interrupt)
  );

  always #5 clk = ~clk;

  function automatic bit legalLamp(input int v);
    return (v == 1) || (v == 2) || (v == 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model state is advanced with timer effects first so a same-cycle write never
  // influences the tick or command seen on that edge.
  task automatic updateModel(input bit r, input int pid, input int data, input bit ws,
                             input bit tk, input bit ak);
    bit setInt, start, stop;
    int nsC, ewC;
    if (r) begin
      mCe = 0; mGreen = 0; mRem = 0; mBusy = 0; mInt = 0;
      mNs = 4; mEw = 4; mPed = 0;
    end else begin
      setInt = 0;
      start  = ws && (pid == 4) && (data % 2 == 1) && ((data / 2) % 2 == 0);
      stop   = ws && (pid == 4) && ((data / 2) % 2 == 1);
      if (stop) begin
        mBusy = 0; mRem = 0;
      end else if (start) begin
        if (mGreen == 0) begin
          mBusy = 0; mRem = 0; setInt = 1;
        end else begin
          mBusy = 1; mRem = mGreen;
        end
      end else if (mBusy == 1 && tk && mCe == 1) begin
        mRem = mRem - 1;
        if (mRem == 0) begin
          mBusy = 0; setInt = 1;
        end
      end
      if (setInt) mInt = 1;
      else if (ak) mInt = 0;
      if (ws) begin
        if (pid == 1) mCe = data % 2;
        if (pid == 2) mGreen = data % 64;
        if (pid == 3) begin
          nsC = legalLamp(data % 8) ? data % 8 : 4;
          ewC = legalLamp((data / 8) % 8) ? (data / 8) % 8 : 4;
          mPed = (((data / 64) % 2 == 1) && nsC != 1 && ewC != 1) ? 1 : 0;
          if (nsC == 1 && ewC == 1) begin
            nsC = 4; ewC = 4;
          end
          mNs = nsC; mEw = ewC;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".ce"}, 32'(ce), 32'(mCe));
    check({tag, ".green"}, 32'(green_time), 32'(mGreen));
    check({tag, ".ns"}, 32'(ns_light), 32'(mNs));
    check({tag, ".ew"}, 32'(ew_light), 32'(mEw));
    check({tag, ".ped"}, 32'(ped_walk), 32'(mPed));
    check({tag, ".busy"}, 32'(timer_busy), 32'(mBusy));
    check({tag, ".rem"}, 32'(remaining), 32'(mRem));
    check({tag, ".int"}, 32'(interrupt), 32'(mInt));
  endtask

  task automatic applyStimulus(input string tag, input bit r, input int pid, input int data,
                               input bit ws, input bit tk, input bit ak);
    rst = r;
    port_id = 8'(pid);
    out_port = 8'(data);
    write_strobe = ws;
    sec_tick = tk;
    interrupt_ack = ak;
    @(posedge clk);
    #1;
    updateModel(r, pid, data, ws, tk, ak);
    rst = 1'b0;
    write_strobe = 1'b0;
    sec_tick = 1'b0;
    interrupt_ack = 1'b0;
    checkOutput(tag);
  endtask

  task automatic wr(input string tag, input int pid, input int data);
    applyStimulus(tag, 1'b0, pid, data, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tick(input string tag);
    applyStimulus(tag, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int pid, data;
    bit r, ws, tk, ak;
    mCe = 0; mGreen = 0; mRem = 0; mBusy = 0; mInt = 0; mNs = 4; mEw = 4; mPed = 0;
    @(negedge clk);

    // Reset with random writes in flight
    applyStimulus("rst0", 1'b1, 3, int'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
    applyStimulus("rst1", 1'b1, 4, 1, 1'b1, 1'b1, 1'b1);
    check("rst_ns_const", 32'(ns_light), 32'h4);
    check("rst_ew_const", 32'(ew_light), 32'h4);
    check("rst_int_const", 32'(interrupt), 32'h0);

    // Lamp writes
    wr("lt_ns_green", 3, 8'b0_100_001);
    check("lt1_ns_const", 32'(ns_light), 32'h1);
    check("lt1_ew_const", 32'(ew_light), 32'h4);
    wr("lt_both_green", 3, 8'b1_001_001);
    check("lt2_ns_const", 32'(ns_light), 32'h4);
    check("lt2_ped_const", 32'(ped_walk), 32'h0);
    wr("lt_walk", 3, 8'b1_100_100);
    check("lt3_ped_const", 32'(ped_walk), 32'h1);
    wr("lt_bad_ns", 3, 8'b0_100_011);
    check("lt4_ns_const", 32'(ns_light), 32'h4);

    // Countdown to expiry, then acknowledge
    wr("cd_ce", 1, 1);
    wr("cd_green", 2, 3);
    wr("cd_start", 4, 1);
    check("cd_start_rem", 32'(remaining), 32'h3);
    tick("cd_t1");
    tick("cd_t2");
    check("cd_t2_rem", 32'(remaining), 32'h1);
    tick("cd_t3");
    check("cd_t3_int", 32'(interrupt), 32'h1);
    check("cd_t3_busy", 32'(timer_busy), 32'h0);
    applyStimulus("cd_ack", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("cd_ack_int", 32'(interrupt), 32'h0);

    // START with zero green time
    wr("z_green", 2, 0);
    wr("z_start", 4, 1);
    check("z_int", 32'(interrupt), 32'h1);
    check("z_busy", 32'(timer_busy), 32'h0);
    applyStimulus("z_ack", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // STOP coincident with the final tick
    wr("st_green", 2, 2);
    wr("st_start", 4, 1);
    tick("st_t1");
    applyStimulus("st_stop_tick", 1'b0, 4, 2, 1'b1, 1'b1, 1'b0);
    check("st_int", 32'(interrupt), 32'h0);
    check("st_rem", 32'(remaining), 32'h0);

    // Freeze with ce=0, then reprogram while running
    wr("fz_green", 2, 5);
    wr("fz_start", 4, 1);
    wr("fz_ce0", 1, 0);
    for (int i = 0; i < 5; i++) tick("fz_tick");
    check("fz_rem", 32'(remaining), 32'h5);
    wr("fz_green9", 2, 9);
    check("fz_rem9", 32'(remaining), 32'h5);
    wr("fz_ce1", 1, 1);
    tick("fz_tick_on");
    check("fz_rem4", 32'(remaining), 32'h4);
    wr("fz_restart", 4, 1);
    check("fz_reload", 32'(remaining), 32'h9);
    wr("fz_both", 4, 3);
    check("fz_both_busy", 32'(timer_busy), 32'h0);

    // Ack on the same edge as a new expiry
    wr("cc_green", 2, 1);
    wr("cc_start", 4, 1);
    tick("cc_exp1");
    wr("cc_start2", 4, 1);
    applyStimulus("cc_exp_ack", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    check("cc_int", 32'(interrupt), 32'h1);
    applyStimulus("cc_ack", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Unmapped port and unstrobed write
    wr("um_07", 7, 8'hFF);
    check("um_ns", 32'(ns_light), 32'h4);
    check("um_ce", 32'(ce), 32'h1);
    applyStimulus("um_nostrobe", 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0: pid = 1;
        1: pid = 2;
        2: pid = 3;
        3: pid = 4;
        4: pid = 4;
        default: pid = 7;
      endcase
      data = int'($urandom_range(0, 255));
      if (pid == 2 && $urandom_range(0, 1) == 1) data = int'($urandom_range(0, 6));
      if (pid == 1 && $urandom_range(0, 3) != 0) data = 1;
      r  = ($urandom_range(0, 79) == 0);
      ws = ($urandom_range(0, 2) == 0);
      tk = ($urandom_range(0, 9) < 4);
      ak = ($urandom_range(0, 5) == 0);
      applyStimulus("rnd", r, pid, data, ws, tk, ak);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/out_port_regs.md
# out_port_regs

Output-side port decoder for the traffic-light controller's 8-bit soft processor. It is the write counterpart of the input-port mux.
- Captures `out_port` on `write_strobe` into addressed registers: clock enable, green-light time, light pattern and timer command.
- Runs a seconds-based green-light countdown and raises a latched interrupt on expiry, held until the processor acknowledges it.
- Sits between the processor's output bus and the lamp drivers; `ce` and `green_time` feed back to the input-port mux.

## Interface
Parameters:
- `TIME_W`, default 6: width of green time and countdown.
- `LIGHT_SAFE`, default 3'b100: per-direction value forced on an illegal light field (red).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `port_id`  in  8  processor port address.
- `out_port`  in  8  processor write data.
- `write_strobe`  in  1  one-cycle write qualifier.
- `sec_tick`  in  1  one-cycle pulse, once per second.
- `interrupt_ack`  in  1  processor interrupt acknowledge.
- `ce`  out  1  controller clock enable (port 0x01 bit0).
- `green_time`  out  TIME_W  programmed green duration in seconds.
- `ns_light`  out  3  north-south lamps {R,Y,G}.
- `ew_light`  out  3  east-west lamps {R,Y,G}.
- `ped_walk`  out  1  pedestrian walk lamp.
- `timer_busy`  out  1  countdown running.
- `remaining`  out  TIME_W  seconds left.
- `interrupt`  out  1  expiry interrupt, level, latched.

## Operation
A write is decoded only when `write_strobe`=1. Unmapped addresses are ignored.
- 0x01 CE: `ce` <= `out_port[0]`.
- 0x02 GREEN_TIME: `green_time` <= `out_port[TIME_W-1:0]`. Does not change a countdown already running.
- 0x03 LIGHTS: bits[2:0] go to NS, bits[5:3] to EW, bit6 to `ped_walk`.
  - A field that is not one-hot is replaced by LIGHT_SAFE.
  - If both fields are green after that check, both become LIGHT_SAFE.
  - If either field is green, `ped_walk` is forced to 0.
- 0x04 TIMER_CMD: bit0 START, bit1 STOP. If both are set, STOP wins.

Timer state machine, states IDLE and RUN:
- IDLE, START:
  - `green_time`≠0: load `remaining` <= `green_time` and go to RUN.
  - `green_time`=0: stay in IDLE and set `interrupt`.
- RUN, START: reload `remaining` from `green_time` and stay in RUN.
- RUN, STOP: go to IDLE and clear `remaining` to 0. No interrupt.
- RUN, `sec_tick`=1 and `ce`=1: decrement `remaining`. When 1 becomes 0, go to IDLE and set `interrupt`.
- RUN with `ce`=0: ticks are ignored and the count freezes.

Interrupt rules:
- `interrupt` stays set until `interrupt_ack`=1, which clears it.
- If a set event and `interrupt_ack` occur in the same cycle, the set wins.

Other simultaneous events:
- START or STOP in the same cycle as `sec_tick`: the command wins and the tick is dropped.
- STOP in the same cycle as expiry: STOP wins and no interrupt is raised.

`timer_busy` = (state == RUN).

## Timing
- All outputs are registered.
- A write accepted at edge N is visible on outputs after edge N.
- `remaining` changes on the edge that samples `sec_tick`. `interrupt` rises on that same edge.
- `interrupt_ack` takes effect at the next edge.
- Reset values, applied at the first edge with `rst`=1 and overriding every other input:
  - `ce`=0, `green_time`=0, `remaining`=0.
  - `ns_light`=`ew_light`=3'b100, `ped_walk`=0.
  - state IDLE, `timer_busy`=0, `interrupt`=0.
- Asserting `rst` mid-countdown aborts the countdown and raises no interrupt.

## Structure
Shared package `tl_pkg` holds:
- Port address constants: PORT_CE=8'h01, PORT_GREEN=8'h02, PORT_LIGHTS=8'h03, PORT_TIMER=8'h04.
- Light encodings: RED=3'b100, YEL=3'b010, GRN=3'b001.
- Timer state enum {IDLE, RUN}.

Split the countdown into one sub-module, `gl_countdown`. It takes load, stop, tick, enable and load value, and produces remaining, busy and an expiry pulse. The top level owns decode, the light safety check and the interrupt latch.

## Test plan
- **Reset:** assert `rst` with random port writes in flight -> all outputs at reset values; lights 3'b100/3'b100.
- **Light writes:**
  - Write 0x03 ← 8'b0_100_001 -> NS=001, EW=100, `ped_walk`=0.
  - Write 8'b1_001_001 -> both fields 100, `ped_walk`=0.
  - Write 8'b1_100_100 -> `ped_walk`=1.
  - Write NS field=011 -> NS=100.
- **Countdown to expiry:** `ce`=1, `green_time`=3, START, then 3 `sec_tick`s -> `remaining` 3,2,1,0; `interrupt` rises on the 3rd tick edge and `timer_busy` falls with it; `interrupt_ack` clears it one edge later.
- **Edge commands:**
  - START with `green_time`=0 -> `interrupt`=1 next edge, `timer_busy` stays 0.
  - STOP coincident with the final tick -> no interrupt, `remaining`=0.
- **Freeze and reprogram:** `ce`=0 during RUN with 5 ticks -> `remaining` unchanged. Write GREEN_TIME=9 while running -> count unaffected until the next START reloads 9.
- **Concurrency:** `interrupt_ack` on the same edge as a new expiry -> `interrupt` stays 1. Write to unmapped port 0x07 -> no output change.
